// File: rtl/multiplicador_pkg.sv
// Shared widths, constants and FSM state type for the multiplicador price calculator.
package multiplicador_pkg;

  localparam int unsigned W_WIDTH    = 12;
  localparam int unsigned P_WIDTH    = 10;
  localparam int unsigned OUT_WIDTH  = 10;
  localparam int unsigned PROD_WIDTH = 22;

  localparam int unsigned DIVISOR    = 1000;
  localparam int unsigned ROUND_BIAS = 500;
  localparam int unsigned OUT_MAX    = 1023;

  localparam int unsigned MUL_CYCLES = 12;
  localparam int unsigned DIV_CYCLES = 22;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIN
  } state_t;

endpackage

// File: rtl/multiplicador_div1000.sv
// 22-bit restoring divider by the constant 1000, one quotient bit per step.
module multiplicador_div1000
  import multiplicador_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [PROD_WIDTH-1:0] dividend,
  output logic [PROD_WIDTH-1:0] quotient
);

  logic [9:0]            rem;
  logic [PROD_WIDTH-1:0] dq;
  logic [10:0]           trial;
  logic [10:0]           diff;
  logic                  fits;

  // dq shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    trial = {rem, dq[PROD_WIDTH-1]};
    diff  = trial - 11'(DIVISOR);
    fits  = (trial >= 11'(DIVISOR));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      dq  <= '0;
    end else if (load) begin
      rem <= '0;
      dq  <= dividend;
    end else if (step) begin
      if (fits) begin
        rem <= diff[9:0];
        dq  <= {dq[PROD_WIDTH-2:0], 1'b1};
      end else begin
        rem <= trial[9:0];
        dq  <= {dq[PROD_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient = dq;

endmodule

// File: rtl/multiplicador.sv
// Price = round/trunc(weight * unit price / 1000), saturated to 10 bits, 35-cycle latency.
// Build option: MULTIPLICADOR_ROUND_EN selects round-half-up (bias 500) instead of truncation.
module multiplicador
  import multiplicador_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W_WIDTH-1:0]   quilos_tara,
  input  logic [P_WIDTH-1:0]   eurosporquilo,
  output logic [OUT_WIDTH-1:0] preco,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

`ifdef MULTIPLICADOR_ROUND_EN
  localparam logic [PROD_WIDTH-1:0] BIAS = PROD_WIDTH'(ROUND_BIAS);
`else
  localparam logic [PROD_WIDTH-1:0] BIAS = '0;
`endif

  state_t                state, state_next;
  logic [4:0]            cnt;
  logic [W_WIDTH-1:0]    w_sh;
  logic [PROD_WIDTH-1:0] mcand;
  logic [PROD_WIDTH-1:0] acc;
  logic [PROD_WIDTH-1:0] partial;
  logic [PROD_WIDTH-1:0] dividend;
  logic [PROD_WIDTH-1:0] quotient;
  logic                  mul_last;
  logic                  div_last;
  logic                  div_load;
  logic                  div_step;

  // bias is folded into the final multiply iteration so the divider loads on the same edge
  always_comb begin
    partial  = w_sh[0] ? (acc + mcand) : acc;
    dividend = partial + BIAS;
    mul_last = (cnt == 5'(MUL_CYCLES - 1));
    div_last = (cnt == 5'(DIV_CYCLES - 1));
  end

  always_comb begin
    state_next = state;
    div_load   = 1'b0;
    div_step   = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = MUL;
      MUL: begin
        if (mul_last) begin
          state_next = DIV;
          div_load   = 1'b1;
        end
      end
      DIV: begin
        div_step = 1'b1;
        if (div_last) state_next = FIN;
      end
      FIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      w_sh     <= '0;
      mcand    <= '0;
      acc      <= '0;
      preco    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            w_sh  <= quilos_tara;
            mcand <= PROD_WIDTH'(eurosporquilo);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        MUL: begin
          acc   <= partial;
          w_sh  <= w_sh >> 1;
          mcand <= mcand << 1;
          cnt   <= mul_last ? 5'd0 : cnt + 5'd1;
        end
        DIV: cnt <= cnt + 5'd1;
        FIN: begin
          done <= 1'b1;
          if (quotient > PROD_WIDTH'(OUT_MAX)) begin
            preco    <= '1;
            overflow <= 1'b1;
          end else begin
            preco    <= quotient[OUT_WIDTH-1:0];
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb busy = (state != IDLE);

  multiplicador_div1000 u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (dividend),
    .quotient (quotient)
  );

endmodule

// File: tb/tb_multiplicador.sv
// Self-checking bench for multiplicador: arithmetic reference model plus directed vectors.
module tb_multiplicador;

`ifdef MULTIPLICADOR_ROUND_EN
  localparam int unsigned TB_BIAS  = 500;
  localparam int unsigned EXP_1234 = 700;
  localparam int unsigned EXP_1    = 1;
`else
  localparam int unsigned TB_BIAS  = 0;
  localparam int unsigned EXP_1234 = 699;
  localparam int unsigned EXP_1    = 0;
`endif
  localparam int unsigned LATENCY = 35;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] quilos_tara;
  logic [9:0]  eurosporquilo;
  logic [9:0]  preco;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  multiplicador dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .quilos_tara   (quilos_tara),
    .eurosporquilo (eurosporquilo),
    .preco         (preco),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a countdown of cycles to completion plus plain arithmetic on captured operands
  int unsigned m_cnt;
  int unsigned m_w, m_p, m_q;
  int unsigned m_preco;
  logic        m_ov, m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_preco = 0; m_ov = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_q = (m_w * m_p + TB_BIAS) / 1000;
          if (m_q > 1023) begin m_preco = 1023; m_ov = 1'b1; end
          else begin m_preco = m_q; m_ov = 1'b0; end
          m_done = 1'b1;
        end
      end else if (start) begin
        m_w = quilos_tara; m_p = eurosporquilo; m_cnt = LATENCY;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (busy !== (m_cnt > 0) || done !== m_done || overflow !== m_ov ||
        preco !== 10'(m_preco)) begin
      errors++;
      $display("FAIL cycle_model t=%0t busy=%b exp=%b done=%b exp=%b preco=%0d exp=%0d ovf=%b exp=%b",
               $time, busy, (m_cnt > 0), done, m_done, preco, m_preco, overflow, m_ov);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_op(input int unsigned w, input int unsigned p, input int exp_preco,
                        input int exp_ov, input bit disturb, input string name);
    int n;
    @(posedge clk); #1;
    quilos_tara = 12'(w); eurosporquilo = 10'(p); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (disturb && n == 5) begin quilos_tara = 12'd4095; eurosporquilo = 10'd1023; end
      if (disturb && n == 10) start = 1'b1;
      if (disturb && n == 11) start = 1'b0;
    end
    chk({name, "_latency"}, n, LATENCY);
    chk({name, "_preco"}, int'(preco), exp_preco);
    chk({name, "_ovf"}, int'(overflow), exp_ov);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
  endtask

  initial begin
    int nd;
    int n;
    int t_done[$];
    rst = 1'b1; start = 1'b0; quilos_tara = '0; eurosporquilo = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_preco", int'(preco), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_ovf", int'(overflow), 0);
    rst = 1'b0;

    run_op(1000, 250, 250, 0, 1'b0, "w1000_p250");
    run_op(1234, 567, EXP_1234, 0, 1'b0, "w1234_p567");
    run_op(1, 500, EXP_1, 0, 1'b0, "w1_p500");
    run_op(1500, 682, 1023, 0, 1'b0, "w1500_p682");
    run_op(1500, 683, 1023, 1, 1'b0, "w1500_p683");
    run_op(4095, 1023, 1023, 1, 1'b0, "w4095_p1023");
    run_op(0, 1023, 0, 0, 1'b0, "w0_p1023");

    // operands change mid-run and a second start arrives while busy
    run_op(1000, 250, 250, 0, 1'b1, "disturbed");
    count_dones(40, nd);
    chk("disturbed_extra_done", nd, 0);

    // start held high: back-to-back results
    @(posedge clk); #1;
    quilos_tara = 12'd100; eurosporquilo = 10'd100; start = 1'b1;
    n = 0;
    while (t_done.size() < 3 && n < 150) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) begin
        t_done.push_back(n);
        if (t_done.size() == 1) chk("held_first_preco", int'(preco), 10);
        if (t_done.size() == 2) chk("held_second_preco", int'(preco), 600);
        quilos_tara = 12'd2000; eurosporquilo = 10'd300;
      end
    end
    start = 1'b0;
    chk("held_done_count", t_done.size(), 3);
    if (t_done.size() == 3) begin
      chk("held_interval1", t_done[1] - t_done[0], 36);
      chk("held_interval2", t_done[2] - t_done[1], 36);
    end
    n = 0;
    while (busy !== 1'b0 && n < 60) begin @(posedge clk); #1; n++; end
    chk("held_drain_timeout", int'(n < 60), 1);

    // reset in the middle of a computation
    @(posedge clk); #1;
    quilos_tara = 12'd2000; eurosporquilo = 10'd300; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_preco", int'(preco), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    count_dones(40, nd);
    chk("midrst_no_done", nd, 0);
    run_op(1000, 250, 250, 0, 1'b0, "after_rst");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
